// File: rtl/qam_demod.sv
// 16-QAM coherent demodulator: correlates the passband stream against a local carrier,
// integrates each symbol, slices to the nearest level and queues symbols in a small FIFO.
module qam_demod #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_W           = 24,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       axi_clk,
    input  logic       axi_rstn,
    input  logic       qam_valid,
    input  logic [9:0] qam_in,
    input  logic       cor_valid,
    input  logic       cor_zero,
    input  logic [7:0] sin,
    input  logic [7:0] cos,
    output logic       dout_valid,
    output logic [3:0] dout,
    input  logic       dout_ready,
    output logic       sync_err,
    output logic       overflow
);

    localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [ACC_W-1:0] THR     = ACC_W'(SAMPLES_PER_SYM * 4096);
    localparam logic signed [ACC_W-1:0] NEG_THR = -THR;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DECIDE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_en;
    logic             take, first, last, sync_hit;

    assign acc_en = qam_valid && cor_valid;

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_err <= sync_hit;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        first    = 1'b0;
        last     = 1'b0;
        sync_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_en && cor_zero) begin
                    take    = 1'b1;
                    first   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (acc_en) begin
                    if (cor_zero) begin
                        // Carrier phase zero restarts the symbol; a partial one is abandoned.
                        take     = 1'b1;
                        first    = 1'b1;
                        cnt_d    = CNT_W'(1);
                        sync_hit = (cnt_q != '0);
                    end else if (cnt_q != '0) begin
                        take = 1'b1;
                        if (cnt_q == CNT_W'(SAMPLES_PER_SYM - 1)) begin
                            last    = 1'b1;
                            cnt_d   = '0;
                            state_d = DECIDE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            DECIDE: begin
                state_d = ACCUM;
                if (acc_en && cor_zero) begin
                    take  = 1'b1;
                    first = 1'b1;
                    cnt_d = CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: 3Q6 x 1Q6 products, LSB 2^-12.
    logic signed [17:0] qam_x, cos_x, sin_x;
    logic signed [17:0] pi_q, pq_q;
    logic               s1_take, s1_first, s1_last;

    assign qam_x = {{8{qam_in[9]}}, qam_in};
    assign cos_x = {{10{cos[7]}}, cos};
    assign sin_x = {{10{sin[7]}}, sin};

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            pi_q     <= '0;
            pq_q     <= '0;
            s1_take  <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_take  <= take;
            s1_first <= first;
            s1_last  <= last;
            if (take) begin
                pi_q <= qam_x * cos_x;
                pq_q <= qam_x * sin_x;
            end
        end
    end

    // Stage 2: integrate over the symbol; the first product loads instead of adding.
    logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
    logic                    s2_last;

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            s2_last <= 1'b0;
        end else begin
            s2_last <= s1_last;
            if (s1_take) begin
                acc_i_q <= s1_first ? ACC_W'(pi_q) : acc_i_q + ACC_W'(pi_q);
                acc_q_q <= s1_first ? ACC_W'(pq_q) : acc_q_q + ACC_W'(pq_q);
            end
        end
    end

    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] acc);
        if (acc >= THR)          return 2'b10;
        else if (!acc[ACC_W-1])  return 2'b11;
        else if (acc >= NEG_THR) return 2'b01;
        else                     return 2'b00;
    endfunction

    logic [3:0] sym;
    assign sym = {slice(acc_i_q), slice(acc_q_q)};

    // Output FIFO, show-ahead; a separate count tells full from empty.
    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, do_push;

    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop     = dout_valid && dout_ready;
    assign do_push = s2_last && (!full || pop);

    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge axi_clk) begin
        if (do_push) mem[wr_ptr] <= sym;
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s2_last && full && !pop) overflow <= 1'b1;
        end
    end

    assign dout_valid = (count != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : 4'h0;

endmodule

// File: tb/tb_qam_demod.sv
// Self-checking bench for qam_demod: a behavioural 16-QAM modulator drives the demodulator
// and recovered symbols are compared with integer correlation sums sliced in the bench.
module tb_qam_demod;

    logic       axi_clk = 1'b0;
    logic       axi_rstn;
    logic       qam_valid, cor_valid, cor_zero;
    logic [9:0] qam_in;
    logic [7:0] sin, cos;
    logic       dout_valid, dout_ready, sync_err, overflow;
    logic [3:0] dout;

    int total = 0;
    int bad   = 0;
    int sync_seen = 0;
    logic [3:0] exp_q[$];
    logic [3:0] rx_q[$];

    int cos_tab[16] = '{64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59};

    qam_demod #(.SAMPLES_PER_SYM(16), .ACC_W(24), .FIFO_DEPTH(4)) dut (
        .axi_clk   (axi_clk),
        .axi_rstn  (axi_rstn),
        .qam_valid (qam_valid),
        .qam_in    (qam_in),
        .cor_valid (cor_valid),
        .cor_zero  (cor_zero),
        .sin       (sin),
        .cos       (cos),
        .dout_valid(dout_valid),
        .dout      (dout),
        .dout_ready(dout_ready),
        .sync_err  (sync_err),
        .overflow  (overflow)
    );

    always #5 axi_clk = ~axi_clk;

    always @(negedge axi_clk) begin
        if (axi_rstn && dout_valid && dout_ready) rx_q.push_back(dout);
        if (sync_err) sync_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int level(input logic [1:0] bits);
        case (bits)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] model_slice(input longint acc);
        if (acc >= 65536)  return 2'b10;
        if (acc >= 0)      return 2'b11;
        if (acc >= -65536) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        qam_valid = 1'b0;
        cor_valid = 1'b0;
        cor_zero  = 1'b0;
        qam_in    = '0;
        sin       = '0;
        cos       = '0;
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic drive(input int q, input int c, input int s, input bit z);
        qam_valid = 1'b1;
        cor_valid = 1'b1;
        cor_zero  = z;
        qam_in    = 10'(q);
        cos       = 8'(c);
        sin       = 8'(s);
        tick();
    endtask

    // Modulate din over nsamp carrier samples; a full symbol is logged as expected output.
    task automatic send_symbol(input logic [3:0] din, input bit gaps, input int nsamp, input bit record);
        int a, b, c, s, q;
        longint ai, aq;
        a  = level(din[3:2]);
        b  = level(din[1:0]);
        ai = 0;
        aq = 0;
        for (int k = 0; k < nsamp; k++) begin
            c = cos_tab[k];
            s = cos_tab[(k + 12) % 16];
            q = a * c + b * s;
            if (gaps && $urandom_range(3) == 0) begin
                qam_valid = 1'b0;
                tick();
            end
            drive(q, c, s, k == 0);
            ai += longint'(q) * c;
            aq += longint'(q) * s;
        end
        if (record && nsamp == 16) exp_q.push_back({model_slice(ai), model_slice(aq)});
        idle();
    endtask

    task automatic send_const(input int q, input int c, input int s);
        for (int k = 0; k < 16; k++) drive(q, c, s, k == 0);
        idle();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && rx_q.size() < exp_q.size(); i++) tick();
        repeat (6) tick();
    endtask

    task automatic compare_queues(input string tag);
        int n;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_sym%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [3:0] seq[6] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3, 4'hC};
        logic [3:0] ovf_seq[6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hE, 4'h9};
        int sync_base;

        idle();
        dout_ready = 1'b1;
        axi_rstn   = 1'b0;
        repeat (3) tick();
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout", dout, 4'h0);
        check("rst_sync_err", sync_err, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        axi_rstn = 1'b1;
        repeat (2) tick();

        // First-symbol latency: last sample in cycle t, dout_valid in cycle t+3.
        send_symbol(4'h0, 1'b0, 16, 1'b1);
        @(negedge axi_clk);
        check("lat_t1", dout_valid, 1'b0);
        tick();
        @(negedge axi_clk);
        check("lat_t2", dout_valid, 1'b0);
        tick();
        @(negedge axi_clk);
        check("lat_t3", dout_valid, 1'b1);
        check("lat_dout", dout, exp_q[0]);
        wait_drain();
        compare_queues("latency");

        // Back-to-back loopback.
        sync_base = sync_seen;
        for (int i = 0; i < 6; i++) send_symbol(seq[i], 1'b0, 16, 1'b1);
        wait_drain();
        compare_queues("loopback");
        check("loopback_sync", sync_seen - sync_base, 0);
        check("loopback_ovf", overflow, 1'b0);

        // Every symbol twice with random stall cycles.
        for (int d = 0; d < 16; d++) begin
            send_symbol(4'(d), 1'b1, 16, 1'b1);
            send_symbol(4'(d), 1'b1, 16, 1'b1);
        end
        wait_drain();
        compare_queues("gaps");

        // Slicer boundaries on the I axis (Q axis held at zero -> +1).
        send_const(0, 64, 0);
        exp_q.push_back(4'hF);
        send_const(64, 64, 0);
        exp_q.push_back(4'hB);
        send_const(-64, 64, 0);
        exp_q.push_back(4'h7);
        wait_drain();
        compare_queues("slicer");

        // Phase zero mid-symbol.
        sync_base = sync_seen;
        send_symbol(4'h9, 1'b0, 7, 1'b0);
        send_symbol(4'h6, 1'b0, 16, 1'b1);
        wait_drain();
        check("sync_pulses", sync_seen - sync_base, 1);
        compare_queues("sync");

        // Output backpressure and overflow.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_symbol(ovf_seq[i], 1'b0, 16, 1'b1);
        repeat (5) tick();
        check("ovf_before", overflow, 1'b0);
        check("ovf_full_valid", dout_valid, 1'b1);
        for (int i = 4; i < 6; i++) send_symbol(ovf_seq[i], 1'b0, 16, 1'b1);
        repeat (5) tick();
        check("ovf_after", overflow, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_clk);
            check("ovf_stable", dout, exp_q[0]);
            tick();
        end
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        dout_ready = 1'b1;
        wait_drain();
        compare_queues("overflow");
        check("ovf_sticky", overflow, 1'b1);

        // Reset mid-symbol with queued symbols.
        dout_ready = 1'b0;
        send_symbol(4'h2, 1'b0, 16, 1'b1);
        send_symbol(4'hB, 1'b0, 16, 1'b1);
        send_symbol(4'h4, 1'b0, 9, 1'b0);
        repeat (4) tick();
        check("rst2_queued", dout_valid, 1'b1);
        axi_rstn = 1'b0;
        #1;
        check("rst2_valid", dout_valid, 1'b0);
        check("rst2_ovf", overflow, 1'b0);
        tick();
        axi_rstn = 1'b1;
        exp_q.delete();
        rx_q.delete();
        for (int k = 1; k < 6; k++) drive(3 * cos_tab[k], cos_tab[k], cos_tab[(k + 12) % 16], 1'b0);
        idle();
        dout_ready = 1'b1;
        send_symbol(4'hD, 1'b0, 16, 1'b1);
        wait_drain();
        compare_queues("reset");
        check("rst2_ovf_after", overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
